vm_panel_arbiter: RTL and testbench
===================================

VM_PANEL_ARBITER -- requirements
Module: vm_panel_arbiter

Interface
REQ-001 Parameter PRICE, default 10, beverage price in 1,000-won units.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, owner-idle cycles before forced change return.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_coin_a / req_coin_b  input  2 each  coin request: 00 none, 01 1,000 won, 10 5,000 won, 11 invalid.
REQ-007 req_bev_a / req_bev_b  input  1 each  beverage request, held until ack or nack.
REQ-008 req_chg_a / req_chg_b  input  1 each  change-return request, held until ack.
REQ-009 vm_money  input  5  vending machine money_account, 1,000-won units, 0..20.
REQ-010 vm_coin_in  output  2  coin command to vending machine.
REQ-011 vm_beverage_take / vm_change_take  output  1 each  beverage and change commands to vending machine.
REQ-012 ack_a / ack_b  output  1 each  one-cycle pulse: request issued to vending machine.
REQ-013 nack_a / nack_b  output  1 each  one-cycle pulse: beverage request refused, vm_money < PRICE.
REQ-014 owner  output  2  session owner: 00 none, 01 panel A, 10 panel B.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, SESSION, DRAIN, RELEASE.
REQ-017 Commands SHALL be registered: a request sampled at edge N drives exactly one vm_* command, plus ack/nack, for the single cycle following edge N.
REQ-018 At most one of vm_coin_in!=00, vm_beverage_take, vm_change_take SHALL be active in any cycle.
REQ-019 After an issue cycle, the block SHALL ignore all requests for one cycle (cooldown), so commands are spaced by at least 2 cycles.
REQ-020 In IDLE, only a coin request (01/10) SHALL open a session; it is issued, acked, owner is set, and the FSM enters SESSION.
REQ-021 In IDLE, bev/chg requests and coin 11 SHALL be ignored: no command, no ack, no nack.
REQ-022 Simultaneous valid coin requests in IDLE SHALL be resolved round-robin: the panel that did not win last session wins; after reset, A wins.
REQ-023 In SESSION, non-owner requests SHALL be ignored without ack until RELEASE.
REQ-024 In SESSION, if the owner asserts several requests, exactly one SHALL be served per issue slot, priority coin > beverage > change.
REQ-025 Beverage request with vm_money >= PRICE at sampling: issue vm_beverage_take and ack.
REQ-026 Beverage request with vm_money < PRICE at sampling: nack only, no command.
REQ-027 Change request: issue vm_change_take and ack, then enter DRAIN.
REQ-028 The idle counter SHALL clear on every owner ack/nack and on entering SESSION, and increment each other SESSION cycle.
REQ-029 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL issue vm_change_take (no ack), enter DRAIN, and clear the counter.
REQ-030 In DRAIN, no commands SHALL be issued; the FSM leaves for RELEASE on the first cycle vm_money == 0.
REQ-031 RELEASE SHALL last one cycle: owner := 00, last-winner updated, next state IDLE.
REQ-032 Coin 11 from the owner SHALL never be issued or acked; other pending requests are still served.
REQ-033 Overflow above 20 is handled by the vending machine; the block SHALL forward coins regardless of vm_money.

Reset
REQ-034 At a rising edge with rst=1: state IDLE; vm_coin_in 00; vm_beverage_take, vm_change_take, ack_*, nack_* all 0; owner 00; busy 0; idle counter 0; priority to A.
REQ-035 Reset mid-session or mid-DRAIN SHALL abort immediately with no further commands; vm_money is not re-checked.

Verification
REQ-036 A coin 10 and B coin 01 in the same IDLE cycle -> next cycle vm_coin_in=10, ack_a=1, owner=01; B gets no ack while the session is open.
REQ-037 Owner A holds coin 01 and bev together at vm_money=9 -> coin issued first; two cycles later bev is sampled with vm_money=10 -> vm_beverage_take=1 and ack_a.
REQ-038 Owner bev at vm_money=5 -> nack_a one cycle, no vm command, state stays SESSION.
REQ-039 Owner idle TIMEOUT_CYCLES=16 cycles with vm_money=8 -> vm_change_take pulse, DRAIN until vm_money=0, RELEASE, owner=00; next simultaneous A/B coins -> B wins.
REQ-040 Change requested, then rst=1 while in DRAIN with vm_money=3 -> next cycle all outputs zero, owner=00, busy=0.
REQ-041 Owner drives coin 11 plus chg -> only vm_change_take is issued; no coin command.

Source files
------------

// File: rtl/vm_panel_arbiter.sv
// Two-panel front end for a single vending machine: grants one panel a session,
// forwards its coin/beverage/change requests one at a time, and recovers change on owner timeout.
module vm_panel_arbiter #(
  parameter int unsigned PRICE          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_coin_a,
  input  logic [1:0] req_coin_b,
  input  logic       req_bev_a,
  input  logic       req_bev_b,
  input  logic       req_chg_a,
  input  logic       req_chg_b,
  input  logic [4:0] vm_money,
  output logic [1:0] vm_coin_in,
  output logic       vm_beverage_take,
  output logic       vm_change_take,
  output logic       ack_a,
  output logic       ack_b,
  output logic       nack_a,
  output logic       nack_b,
  output logic [1:0] owner,
  output logic       busy
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_W     = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [4:0]     PRICE_W  = 5'(PRICE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SESSION = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] idle_cnt_r, idle_cnt_s, idle_inc_s;
  logic          last_b_r, last_b_s;   // 1: panel B won the previous session
  logic          cool_r, cool_s;       // 1: a command went out on the last edge
  logic [1:0]    owner_r, owner_s;
  logic [1:0]    coin_r, coin_s;
  logic          bev_r, bev_s, chg_r, chg_s;
  logic          ack_a_r, ack_a_s, ack_b_r, ack_b_s;
  logic          nack_a_r, nack_a_s, nack_b_r, nack_b_s;
  logic          busy_r, busy_s;

  logic          own_b_s, own_bev_s, own_chg_s, money_ok_s;
  logic          a_ok_s, b_ok_s, pick_b_s;
  logic [1:0]    own_coin_s;

  function automatic logic coin_valid(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  assign own_b_s    = owner_r[1];
  assign own_coin_s = own_b_s ? req_coin_b : req_coin_a;
  assign own_bev_s  = own_b_s ? req_bev_b  : req_bev_a;
  assign own_chg_s  = own_b_s ? req_chg_b  : req_chg_a;
  assign money_ok_s = (vm_money >= PRICE_W);
  assign a_ok_s     = coin_valid(req_coin_a);
  assign b_ok_s     = coin_valid(req_coin_b);
  // On a tie the panel that lost the previous session takes this one
  assign pick_b_s   = b_ok_s && (!a_ok_s || !last_b_r);
  assign idle_inc_s = idle_cnt_r + CNT_ONE;

  // Next-state and next-command decode
  always_comb begin
    state_s    = state_r;
    idle_cnt_s = idle_cnt_r;
    last_b_s   = last_b_r;
    owner_s    = owner_r;
    cool_s     = 1'b0;
    coin_s     = 2'b00;
    bev_s      = 1'b0;
    chg_s      = 1'b0;
    ack_a_s    = 1'b0;
    ack_b_s    = 1'b0;
    nack_a_s   = 1'b0;
    nack_b_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cool_r && (a_ok_s || b_ok_s)) begin
          state_s    = SESSION;
          idle_cnt_s = CNT_ZERO;
          cool_s     = 1'b1;
          if (pick_b_s) begin
            coin_s  = req_coin_b;
            ack_b_s = 1'b1;
            owner_s = 2'b10;
          end else begin
            coin_s  = req_coin_a;
            ack_a_s = 1'b1;
            owner_s = 2'b01;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SESSION: begin
        if (cool_r) begin
          idle_cnt_s = idle_inc_s;
        end else if (coin_valid(own_coin_s)) begin
          coin_s     = own_coin_s;
          ack_a_s    = !own_b_s;
          ack_b_s    = own_b_s;
          cool_s     = 1'b1;
          idle_cnt_s = CNT_ZERO;
        end else if (own_bev_s && money_ok_s) begin
          bev_s      = 1'b1;
          ack_a_s    = !own_b_s;
          ack_b_s    = own_b_s;
          cool_s     = 1'b1;
          idle_cnt_s = CNT_ZERO;
        end else if (own_bev_s) begin
          nack_a_s   = !own_b_s;
          nack_b_s   = own_b_s;
          idle_cnt_s = CNT_ZERO;
        end else if (own_chg_s) begin
          chg_s      = 1'b1;
          ack_a_s    = !own_b_s;
          ack_b_s    = own_b_s;
          cool_s     = 1'b1;
          idle_cnt_s = CNT_ZERO;
          state_s    = DRAIN;
        end else if (idle_inc_s >= TO_W) begin
          chg_s      = 1'b1;
          cool_s     = 1'b1;
          idle_cnt_s = CNT_ZERO;
          state_s    = DRAIN;
        end else begin
          idle_cnt_s = idle_inc_s;
        end
      end
      DRAIN: begin
        if (vm_money == 5'd0) begin
          state_s  = RELEASE;
          owner_s  = 2'b00;
          last_b_s = own_b_s;
        end else begin
          state_s = DRAIN;
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        owner_s = 2'b00;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idle_cnt_r <= CNT_ZERO;
      last_b_r   <= 1'b1;
      cool_r     <= 1'b0;
      owner_r    <= 2'b00;
      coin_r     <= 2'b00;
      bev_r      <= 1'b0;
      chg_r      <= 1'b0;
      ack_a_r    <= 1'b0;
      ack_b_r    <= 1'b0;
      nack_a_r   <= 1'b0;
      nack_b_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idle_cnt_r <= idle_cnt_s;
      last_b_r   <= last_b_s;
      cool_r     <= cool_s;
      owner_r    <= owner_s;
      coin_r     <= coin_s;
      bev_r      <= bev_s;
      chg_r      <= chg_s;
      ack_a_r    <= ack_a_s;
      ack_b_r    <= ack_b_s;
      nack_a_r   <= nack_a_s;
      nack_b_r   <= nack_b_s;
      busy_r     <= busy_s;
    end
  end

  assign vm_coin_in       = coin_r;
  assign vm_beverage_take = bev_r;
  assign vm_change_take   = chg_r;
  assign ack_a            = ack_a_r;
  assign ack_b            = ack_b_r;
  assign nack_a           = nack_a_r;
  assign nack_b           = nack_b_r;
  assign owner            = owner_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_vm_panel_arbiter.sv
// Directed scenarios plus random traffic, every cycle compared against a
// session-level reference model of the panel arbiter.
module tb_vm_panel_arbiter;

  localparam int PRICE   = 10;
  localparam int TIMEOUT = 16;

  logic       clk, rst;
  logic [1:0] req_coin_a, req_coin_b;
  logic       req_bev_a, req_bev_b, req_chg_a, req_chg_b;
  logic [4:0] vm_money;
  logic [1:0] vm_coin_in;
  logic       vm_beverage_take, vm_change_take;
  logic       ack_a, ack_b, nack_a, nack_b;
  logic [1:0] owner;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  vm_panel_arbiter dut (
    .clk(clk), .rst(rst),
    .req_coin_a(req_coin_a), .req_coin_b(req_coin_b),
    .req_bev_a(req_bev_a), .req_bev_b(req_bev_b),
    .req_chg_a(req_chg_a), .req_chg_b(req_chg_b),
    .vm_money(vm_money),
    .vm_coin_in(vm_coin_in),
    .vm_beverage_take(vm_beverage_take), .vm_change_take(vm_change_take),
    .ack_a(ack_a), .ack_b(ack_b), .nack_a(nack_a), .nack_b(nack_b),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: session phase, which panel holds it, who won last,
  // whether a command just went out, and how long the owner has been quiet.
  int         m_phase;   // 0 idle, 1 session, 2 drain, 3 release
  int         m_owner;   // 0 none, 1 panel A, 2 panel B
  int         m_last;    // panel that won the previous session
  bit         m_cool;
  int         m_idle;
  logic [1:0] e_coin;
  logic       e_bev, e_chg, e_busy;
  logic       e_ack[1:2];
  logic       e_nack[1:2];
  logic [1:0] e_owner;

  function automatic bit real_coin(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  task automatic model_step();
    logic [1:0] c[1:2];
    logic       bv[1:2];
    logic       cg[1:2];
    bit         cooling, served;
    int         p, w, money;
    c[1] = req_coin_a;  c[2] = req_coin_b;
    bv[1] = req_bev_a;  bv[2] = req_bev_b;
    cg[1] = req_chg_a;  cg[2] = req_chg_b;
    money = int'(vm_money);
    e_coin = 2'b00; e_bev = 1'b0; e_chg = 1'b0;
    e_ack[1] = 1'b0; e_ack[2] = 1'b0; e_nack[1] = 1'b0; e_nack[2] = 1'b0;
    if (rst) begin
      m_phase = 0; m_owner = 0; m_last = 2; m_cool = 1'b0; m_idle = 0;
    end else begin
      cooling = m_cool;
      m_cool  = 1'b0;
      if (m_phase == 0) begin
        if (!cooling && (real_coin(c[1]) || real_coin(c[2]))) begin
          if (real_coin(c[1]) && real_coin(c[2])) w = (m_last == 1) ? 2 : 1;
          else w = real_coin(c[1]) ? 1 : 2;
          e_coin = c[w]; e_ack[w] = 1'b1;
          m_owner = w; m_phase = 1; m_idle = 0; m_cool = 1'b1;
        end
      end else if (m_phase == 1) begin
        p = m_owner;
        served = 1'b0;
        if (!cooling) begin
          if (real_coin(c[p])) begin
            e_coin = c[p]; e_ack[p] = 1'b1; m_cool = 1'b1; served = 1'b1;
          end else if (bv[p]) begin
            served = 1'b1;
            if (money >= PRICE) begin
              e_bev = 1'b1; e_ack[p] = 1'b1; m_cool = 1'b1;
            end else begin
              e_nack[p] = 1'b1;
            end
          end else if (cg[p]) begin
            e_chg = 1'b1; e_ack[p] = 1'b1; m_cool = 1'b1; served = 1'b1;
            m_phase = 2;
          end
        end
        if (served) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (!cooling && m_idle >= TIMEOUT) begin
            e_chg = 1'b1; m_cool = 1'b1; m_phase = 2; m_idle = 0;
          end
        end
      end else if (m_phase == 2) begin
        if (money == 0) begin
          m_phase = 3; m_last = m_owner; m_owner = 0;
        end
      end else begin
        m_phase = 0;
      end
    end
    e_owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_busy  = (m_phase != 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check(tag,
          {21'd0, vm_coin_in, vm_beverage_take, vm_change_take, ack_a, ack_b,
           nack_a, nack_b, owner, busy},
          {21'd0, e_coin, e_bev, e_chg, e_ack[1], e_ack[2],
           e_nack[1], e_nack[2], e_owner, e_busy});
  endtask

  task automatic drive(input logic [1:0] ca, input logic [1:0] cb,
                       input logic ba, input logic bb, input logic xa, input logic xb,
                       input logic [4:0] m);
    req_coin_a = ca; req_coin_b = cb;
    req_bev_a = ba;  req_bev_b = bb;
    req_chg_a = xa;  req_chg_b = xb;
    vm_money = m;
  endtask

  initial begin
    bit seen;
    int wait_cnt;
    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle("reset0");
    cycle("reset1");
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);

    // Simultaneous coins after reset: A wins, B stays unserved
    rst = 1'b0;
    drive(2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle("open");
    check("open_coin", 32'(vm_coin_in), 32'd2);
    check("open_ack_a", 32'(ack_a), 32'd1);
    check("open_owner", 32'(owner), 32'd1);
    drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cycle("b_wait");
      check("b_no_ack", 32'(ack_b), 32'd0);
    end

    // Coin beats beverage; beverage served after the cooldown
    drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9);
    cycle("coin_first");
    check("coin_first_cmd", 32'(vm_coin_in), 32'd1);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10);
    cycle("cooldown");
    check("cooldown_no_bev", 32'(vm_beverage_take), 32'd0);
    cycle("bev");
    check("bev_take", 32'(vm_beverage_take), 32'd1);
    check("bev_ack", 32'(ack_a), 32'd1);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10);
    cycle("bev_after");

    // Beverage refused for lack of money
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
    cycle("nack");
    check("nack_a", 32'(nack_a), 32'd1);
    check("nack_no_cmd", 32'(vm_beverage_take), 32'd0);
    check("nack_busy", 32'(busy), 32'd1);

    // Owner goes quiet: forced change after the timeout, then drain/release
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
    seen = 1'b0;
    wait_cnt = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      cycle("idle_wait");
      if (vm_change_take) begin
        seen = 1'b1;
        wait_cnt = i;
      end
    end
    check("timeout_cycles", 32'(wait_cnt), 32'(TIMEOUT));
    check("timeout_no_ack", 32'(ack_a), 32'd0);
    for (int i = 0; i < 3; i++) cycle("drain_hold");
    check("drain_busy", 32'(busy), 32'd1);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle("release");
    check("release_owner", 32'(owner), 32'd0);
    cycle("back_idle");
    check("idle_busy", 32'(busy), 32'd0);
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle("rr_open");
    check("rr_ack_b", 32'(ack_b), 32'd1);
    check("rr_owner", 32'(owner), 32'd2);

    // Invalid coin alongside change: only change goes out
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    cycle("pre_chg");
    drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    cycle("chg");
    check("chg_take", 32'(vm_change_take), 32'd1);
    check("chg_no_coin", 32'(vm_coin_in), 32'd0);
    check("chg_ack_b", 32'(ack_b), 32'd1);

    // Reset during drain aborts the session
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    cycle("drain3");
    rst = 1'b1;
    cycle("abort");
    check("abort_owner", 32'(owner), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cycle("after_abort");

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
            ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 20)));
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
